// File: rtl/r5fp_mul_result_stage.sv
// Result/retire stage behind R5FP_mul: extended-exponent to IEEE conversion, 2-entry FIFO, sticky fflags.
// Optional macro R5FP_MUL_RES_NAN_CANON_EN stores every NaN as the canonical quiet NaN.

module R5FP_exp_decr #(
  parameter int EXP_W = 5,
  parameter int SIG_W = 10
) (
  input  logic [EXP_W+SIG_W+1:0] a,
  output logic [EXP_W+SIG_W:0]   z
);

  // Extended exponent is the IEEE exponent offset by 2^(EXP_W-1); 0 and all-ones stay reserved.
  localparam logic [EXP_W:0] EXP_OFS = (EXP_W+1)'(2**(EXP_W-1));
  localparam logic [EXP_W:0] EXP_SUB = EXP_OFS + (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_OVF = EXP_OFS + (EXP_W+1)'(2**EXP_W - 1);

  logic             w_sign;
  logic [EXP_W:0]   w_extExp;
  logic [SIG_W-1:0] w_sig;
  logic [EXP_W:0]   w_shift;
  logic [SIG_W-1:0] w_denorm;

  assign w_sign   = a[EXP_W+SIG_W+1];
  assign w_extExp = a[EXP_W+SIG_W:SIG_W];
  assign w_sig    = a[SIG_W-1:0];
  assign w_shift  = EXP_SUB - w_extExp;
  assign w_denorm = SIG_W'({1'b1, w_sig} >> w_shift);

  always_comb begin
    z = {w_sign, {EXP_W{1'b0}}, w_denorm};
    if (w_extExp == '1) begin
      z = {w_sign, {EXP_W{1'b1}}, w_sig};
    end else if (w_extExp == '0) begin
      z = {w_sign, {(EXP_W+SIG_W){1'b0}}};
    end else if (w_extExp >= EXP_OVF) begin
      z = {w_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
    end else if (w_extExp >= EXP_SUB) begin
      z = {w_sign, EXP_W'(w_extExp - EXP_OFS), w_sig};
    end
  end

endmodule

module r5fp_mul_result_stage #(
  parameter int EXP_W = 5,
  parameter int SIG_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+SIG_W+1:0] in_z,
  input  logic [7:0]             in_status,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+SIG_W:0]   out_z,
  output logic [7:0]             out_status,
  output logic [TAG_W-1:0]       out_tag,
  output logic [4:0]             fflags,
  input  logic                   fflags_clr
);

  localparam int Z_W = EXP_W + SIG_W + 1;

  logic [Z_W-1:0]   w_conv;
  logic [Z_W-1:0]   w_store;
  logic             w_push;
  logic             w_pop;
  logic [4:0]       w_retFlags;

  logic [Z_W-1:0]   r_memZ      [2];
  logic [7:0]       r_memStatus [2];
  logic [TAG_W-1:0] r_memTag    [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic [4:0]       r_fflags;

  R5FP_exp_decr #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_expDecr (
    .a (in_z),
    .z (w_conv)
  );

`ifdef R5FP_MUL_RES_NAN_CANON_EN
  localparam logic [Z_W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
  assign w_store = ((w_conv[Z_W-2:SIG_W] == '1) && (w_conv[SIG_W-1:0] != '0)) ? CANON_NAN : w_conv;
`else
  assign w_store = w_conv;
`endif

  // Handshakes depend only on registered occupancy, never on out_ready.
  assign in_ready   = (r_count != 2'd2);
  assign out_valid  = (r_count != 2'd0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;

  assign out_z      = r_memZ[r_rdPtr];
  assign out_status = r_memStatus[r_rdPtr];
  assign out_tag    = r_memTag[r_rdPtr];
  assign fflags     = r_fflags;

  // {NV, DZ, OF, UF, NX}; UF only counts when the tiny result was also inexact.
  assign w_retFlags = {out_status[2], 1'b0, out_status[4], out_status[3] & out_status[5], out_status[5]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_memZ[0]      <= '0;
      r_memZ[1]      <= '0;
      r_memStatus[0] <= '0;
      r_memStatus[1] <= '0;
      r_memTag[0]    <= '0;
      r_memTag[1]    <= '0;
      r_wrPtr        <= 1'b0;
      r_rdPtr        <= 1'b0;
      r_count        <= 2'd0;
      r_fflags       <= 5'd0;
    end else begin
      if (w_push) begin
        r_memZ[r_wrPtr]      <= w_store;
        r_memStatus[r_wrPtr] <= in_status;
        r_memTag[r_wrPtr]    <= in_tag;
        r_wrPtr              <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_fflags <= (fflags_clr ? 5'd0 : r_fflags) | w_retFlags;
      end else if (fflags_clr) begin
        r_fflags <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_r5fp_mul_result_stage.sv
// Scoreboard bench for r5fp_mul_result_stage: stimulus pushes expected entries, a negedge monitor pops and compares.
// Honours R5FP_MUL_RES_NAN_CANON_EN for the expected NaN encoding.

module tb_r5fp_mul_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [16:0] inZ;
  logic [7:0]  inStatus;
  logic [3:0]  inTag;
  logic        outValid;
  logic        outReady;
  logic [15:0] outZ;
  logic [7:0]  outStatus;
  logic [3:0]  outTag;
  logic [4:0]  fflags;
  logic        fflagsClr;

  typedef struct {
    logic [15:0] z;
    logic [7:0]  st;
    logic [3:0]  tag;
  } entry_t;

  entry_t      sbQ[$];
  entry_t      monE;
  int          checksTotal  = 0;
  int          checksPassed = 0;
  int          retired      = 0;
  logic        heldValid    = 1'b0;
  logic [27:0] heldBus      = '0;

  r5fp_mul_result_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_z       (inZ),
    .in_status  (inStatus),
    .in_tag     (inTag),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_z      (outZ),
    .out_status (outStatus),
    .out_tag    (outTag),
    .fflags     (fflags),
    .fflags_clr (fflagsClr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compares every retiring head against the scoreboard and checks stalled heads stay put.
  always @(negedge clk) begin
    if (!reset) begin
      if (heldValid && outValid)
        checkOutput("hold_stable", 32'({outZ, outStatus, outTag}), 32'(heldBus));
      if (outValid && outReady) begin
        if (sbQ.size() == 0) begin
          checksTotal++;
          $display("[TB] FAIL unexpected_retire: got tag %0h, expected no output", outTag);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("retire_z", 32'(outZ), 32'(monE.z));
          checkOutput("retire_status", 32'(outStatus), 32'(monE.st));
          checkOutput("retire_tag", 32'(outTag), 32'(monE.tag));
          retired++;
        end
      end
    end
    heldValid = !reset && outValid && !outReady;
    heldBus   = {outZ, outStatus, outTag};
  end

  task automatic applyStimulus(input logic [16:0] z, input logic [7:0] st, input logic [3:0] tag,
                               input logic [15:0] expZ, output int waited);
    entry_t e;
    waited   = 0;
    inZ      = z;
    inStatus = st;
    inTag    = tag;
    inValid  = 1'b1;
    @(negedge clk);
    while (!inReady && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!inReady) begin
      checksTotal++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 for tag %0h, expected accept within 50 cycles", tag);
      inValid = 1'b0;
      return;
    end
    e.z   = expZ;
    e.st  = st;
    e.tag = tag;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL drain_timeout: got %0d entries pending, expected 0", sbQ.size());
      sbQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int r0;
    logic [15:0] nanExp;
`ifdef R5FP_MUL_RES_NAN_CANON_EN
    nanExp = 16'h7E00;
`else
    nanExp = 16'hFD55;
`endif
    reset     = 1'b1;
    inValid   = 1'b0;
    inZ       = '0;
    inStatus  = '0;
    inTag     = '0;
    outReady  = 1'b0;
    fflagsClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_fields", 32'({outZ, outStatus, outTag}), 32'd0);
    checkOutput("reset_fflags", 32'(fflags), 32'd0);

    // Single push of 1.0 with latency-1 output.
    outReady = 1'b1;
    applyStimulus(17'h07C00, 8'h00, 4'd3, 16'h3C00, w);
    checkOutput("first_out_valid", 32'(outValid), 32'd1);
    drain();
    checkOutput("first_fflags", 32'(fflags), 32'd0);

    // Backpressure: third push held off until the consumer resumes.
    outReady = 1'b0;
    r0 = retired;
    applyStimulus(17'h18500, 8'h00, 4'd1, 16'hC500, w);
    applyStimulus(17'h04000, 8'h00, 4'd2, 16'h0200, w);
    checkOutput("full_in_ready", 32'(inReady), 32'd0);
    fork
      applyStimulus(17'h10000, 8'h01, 4'd3, 16'h8000, w);
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("holdoff_in_ready", 32'(inReady), 32'd0);
        outReady = 1'b1;
      end
    join
    drain();
    checkOutput("backpressure_retired", 32'(retired - r0), 32'd3);

    // Sticky flags accumulate, then clear alone.
    applyStimulus(17'h04000, 8'h28, 4'd4, 16'h0200, w);
    drain();
    checkOutput("fflags_uf_nx", 32'(fflags), 32'b00011);
    applyStimulus(17'h1FD55, 8'h04, 4'd5, nanExp, w);
    drain();
    checkOutput("fflags_nv", 32'(fflags), 32'b10011);
    fflagsClr = 1'b1;
    @(posedge clk);
    #1;
    fflagsClr = 1'b0;
    checkOutput("fflags_clr_alone", 32'(fflags), 32'b00000);

    // Clear coincident with a retire keeps only the new flags.
    applyStimulus(17'h18500, 8'h04, 4'd6, 16'hC500, w);
    drain();
    checkOutput("fflags_nv_only", 32'(fflags), 32'b10000);
    outReady = 1'b0;
    applyStimulus(17'h07C00, 8'h20, 4'd7, 16'h3C00, w);
    outReady  = 1'b1;
    fflagsClr = 1'b1;
    @(posedge clk);
    #1;
    fflagsClr = 1'b0;
    checkOutput("fflags_clr_retire", 32'(fflags), 32'b00001);

    // Steady stream at occupancy 1.
    outReady = 1'b0;
    r0 = retired;
    applyStimulus(17'h07C00, 8'h00, 4'd0, 16'h3C00, w);
    outReady = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus({1'b0, 6'd31, 6'd0, 4'(i)}, 8'h00, 4'(i), {1'b0, 5'd15, 6'd0, 4'(i)}, w);
      checkOutput("stream_no_stall", 32'(w), 32'd0);
    end
    checkOutput("stream_count_one", 32'({outValid, inReady}), 32'b11);
    drain();
    checkOutput("stream_retired", 32'(retired - r0), 32'd21);

    // Reset with two entries held discards them and the sticky flags.
    outReady = 1'b0;
    applyStimulus(17'h18500, 8'h24, 4'd10, 16'hC500, w);
    applyStimulus(17'h07C00, 8'h10, 4'd11, 16'h3C00, w);
    reset    = 1'b1;
    inValid  = 1'b1;
    inZ      = 17'h07C00;
    inTag    = 4'd12;
    outReady = 1'b1;
    sbQ.delete();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("midreset_out_valid", 32'(outValid), 32'd0);
    checkOutput("midreset_in_ready", 32'(inReady), 32'd1);
    checkOutput("midreset_fflags", 32'(fflags), 32'd0);
    checkOutput("midreset_out_fields", 32'({outZ, outStatus, outTag}), 32'd0);

    outReady = 1'b1;
    applyStimulus(17'h07C00, 8'h20, 4'd9, 16'h3C00, w);
    drain();
    checkOutput("post_reset_fflags", 32'(fflags), 32'b00001);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
